// File: rtl/boot_pkg.sv
// Shared types for the boot/run sequencer.
//   boot_state_t : sequencer FSM states
//   region_t     : canonical target-memory region ids
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_TOUT  = 3'd6
    } boot_state_t;

    typedef enum int unsigned {
        REGION_IMEM = 0,
        REGION_DMEM = 1,
        REGION_RF   = 2,
        REGION_CSR  = 3
    } region_t;

endpackage

// File: rtl/boot_watchdog.sv
// Run-phase watchdog: a clear/enable counter that flags expiry on the
// LIMIT-th enabled cycle after a clear. LIMIT = 0 disables expiry.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronously zero the counter (takes priority over enable)
//   enable   : count this cycle
//   expire   : combinational, high while enabled with count == LIMIT-1
module boot_watchdog #(
    parameter int LIMIT = 300,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            assign expire = enable && (count == CNT_W'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/boot_load_sequencer.sv
// Boot/run controller: holds the core in reset, streams an image into the
// target memories over a valid/ready beat interface, releases the core and
// supervises it with a halt detector and a watchdog.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : pulse that begins a boot sequence
//   s_valid/s_ready     : image beat handshake
//   s_region/addr/data  : beat target region, word address and data
//   s_last              : final beat of the image
//   mem_we/addr/wdata   : registered one-hot write port to the regions
//   core_rst            : processor reset (high everywhere except RUN)
//   core_halt           : processor reports halt
//   done/timeout        : sticky run outcome
//   err_region          : sticky, a beat addressed a missing region
//   load_count          : accepted beats in this sequence, saturating
module boot_load_sequencer
    import boot_pkg::*;
#(
    parameter int  ADDR_W      = 32,
    parameter int  DATA_W      = 32,
    parameter int  NUM_REGIONS = 4,
    parameter int  RESET_HOLD  = 2,
    parameter int  RUN_LIMIT   = 300,
    parameter int  CNT_W       = 16,
    localparam int RID_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [RID_W-1:0]       s_region,
    input  logic [ADDR_W-1:0]      s_addr,
    input  logic [DATA_W-1:0]      s_data,
    input  logic                   s_last,
    output logic [NUM_REGIONS-1:0] mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   core_rst,
    input  logic                   core_halt,
    output logic                   done,
    output logic                   timeout,
    output logic                   err_region,
    output logic [CNT_W-1:0]       load_count
);

    // One bit wider than the region id so the bound itself is representable.
    localparam logic [RID_W:0] REGION_END = (RID_W + 1)'(NUM_REGIONS);

    boot_state_t      state;
    boot_state_t      next_state;
    logic [CNT_W-1:0] hold_cnt;
    logic             accept;
    logic             region_ok;
    logic             start_seq;
    logic             hold_last;
    logic             wd_expire;

    assign accept    = (state == ST_LOAD) && s_valid;
    assign region_ok = {1'b0, s_region} < REGION_END;
    assign hold_last = hold_cnt == CNT_W'(RESET_HOLD - 1);
    // start only counts where a new sequence may begin.
    assign start_seq = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_TOUT));

    boot_watchdog #(
        .LIMIT (RUN_LIMIT),
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != ST_RUN),
        .enable (state == ST_RUN),
        .expire (wd_expire)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_HOLD;
            ST_HOLD:  if (hold_last) next_state = ST_LOAD;
            ST_LOAD:  if (accept && s_last) next_state = ST_DRAIN;
            ST_DRAIN: next_state = ST_RUN;
            ST_RUN: begin
                // Halt takes precedence over a simultaneous watchdog expiry.
                if (core_halt)      next_state = ST_DONE;
                else if (wd_expire) next_state = ST_TOUT;
            end
            ST_DONE,
            ST_TOUT:  if (start) next_state = ST_HOLD;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state; done/timeout are sticky because
    // DONE/TOUT are only left on a new start.
    always_comb begin
        s_ready  = (state == ST_LOAD);
        core_rst = (state != ST_RUN);
        done     = (state == ST_DONE);
        timeout  = (state == ST_TOUT);
    end

    // Reset-hold cycle counter, idle at zero outside HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state != ST_HOLD) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
        end
    end

    // Write register: one-cycle pulse after each accepted beat; address and
    // data return to zero between writes. A beat to a missing region is
    // consumed without a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept && region_ok) begin
            mem_we    <= NUM_REGIONS'(1) << s_region;
            mem_addr  <= s_addr;
            mem_wdata <= s_data;
        end else begin
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end
    end

    // Per-sequence status: cleared by a start that begins a new sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_region <= 1'b0;
            load_count <= '0;
        end else if (start_seq) begin
            err_region <= 1'b0;
            load_count <= '0;
        end else if (accept) begin
            if (!region_ok) err_region <= 1'b1;
            if (load_count != '1) load_count <= load_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_boot_load_sequencer.sv
// Self-checking bench for boot_load_sequencer. Two instances share stimulus:
//   A: 4 regions, 16-bit counters, watchdog 300
//   B: 3 regions, 4-bit counters, watchdog 10 (missing region, saturation)
// A phase/elapsed-cycle model per instance predicts every output each cycle.
module tb_boot_load_sequencer;

    localparam int A_LIMIT = 300;
    localparam int B_LIMIT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [1:0]  s_region = '0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        core_halt = 1'b0;

    logic        a_s_ready, a_core_rst, a_done, a_timeout, a_err_region;
    logic [3:0]  a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [15:0] a_load_count;

    logic        b_s_ready, b_core_rst, b_done, b_timeout, b_err_region;
    logic [2:0]  b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [3:0]  b_load_count;

    always #5 clk = ~clk;

    boot_load_sequencer #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGIONS(4), .RESET_HOLD(2),
        .RUN_LIMIT(A_LIMIT), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_region(s_region),
        .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .core_rst(a_core_rst), .core_halt(core_halt),
        .done(a_done), .timeout(a_timeout), .err_region(a_err_region),
        .load_count(a_load_count)
    );

    boot_load_sequencer #(
        .ADDR_W(32), .DATA_W(32), .NUM_REGIONS(3), .RESET_HOLD(2),
        .RUN_LIMIT(B_LIMIT), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_region(s_region),
        .s_addr(s_addr), .s_data(s_data), .s_last(s_last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .core_rst(b_core_rst), .core_halt(core_halt),
        .done(b_done), .timeout(b_timeout), .err_region(b_err_region),
        .load_count(b_load_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_HOLD, P_LOAD, P_DRAIN, P_RUN, P_DONE, P_TOUT} phase_t;

    phase_t      ph    [2];
    int          age   [2];   // cycles spent in the current phase
    logic [3:0]  e_we  [2];
    logic [31:0] e_addr[2];
    logic [31:0] e_data[2];
    bit          e_err [2];
    int          e_cnt [2];
    int          wr_cnt[2] = '{0, 0};

    task automatic model_reset(input int i);
        ph[i] = P_IDLE; age[i] = 0;
        e_we[i] = '0; e_addr[i] = '0; e_data[i] = '0;
        e_err[i] = 1'b0; e_cnt[i] = 0;
    endtask

    task automatic model_step(input int i);
        int     nreg, lim, cmax;
        bit     acc;
        phase_t nxt;
        nreg = (i == 0) ? 4 : 3;
        lim  = (i == 0) ? A_LIMIT : B_LIMIT;
        cmax = (i == 0) ? 65535 : 15;
        acc  = (ph[i] == P_LOAD) && s_valid;
        if (acc && int'(s_region) < nreg) begin
            e_we[i] = 4'b0001 << s_region; e_addr[i] = s_addr; e_data[i] = s_data;
        end else begin
            e_we[i] = '0; e_addr[i] = '0; e_data[i] = '0;
        end
        if (acc && int'(s_region) >= nreg) e_err[i] = 1'b1;
        if (acc && e_cnt[i] < cmax) e_cnt[i]++;
        nxt = ph[i];
        case (ph[i])
            P_IDLE:  if (start) nxt = P_HOLD;
            P_HOLD:  if (age[i] == 1) nxt = P_LOAD;   // two hold cycles
            P_LOAD:  if (acc && s_last) nxt = P_DRAIN;
            P_DRAIN: nxt = P_RUN;
            P_RUN: begin
                if (core_halt) nxt = P_DONE;
                else if (age[i] == lim - 1) nxt = P_TOUT;
            end
            default: if (start) begin
                nxt = P_HOLD; e_err[i] = 1'b0; e_cnt[i] = 0;
            end
        endcase
        if (nxt != ph[i]) begin ph[i] = nxt; age[i] = 0; end
        else age[i]++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0); model_reset(1);
        end else begin
            model_step(0); model_step(1);
        end
    end

    task automatic compare_one(input string tag, input int i, input logic ready,
                               input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                               input logic crst, input logic dn, input logic to, input logic err,
                               input logic [15:0] cnt);
        check({tag, "_s_ready"},   ready, ph[i] == P_LOAD);
        check({tag, "_mem_we"},    we, e_we[i]);
        check({tag, "_mem_addr"},  addr, e_addr[i]);
        check({tag, "_mem_wdata"}, data, e_data[i]);
        check({tag, "_core_rst"},  crst, ph[i] != P_RUN);
        check({tag, "_done"},      dn, ph[i] == P_DONE);
        check({tag, "_timeout"},   to, ph[i] == P_TOUT);
        check({tag, "_err"},       err, e_err[i]);
        check({tag, "_count"},     cnt, e_cnt[i]);
        check({tag, "_exclusive"}, dn & to, 1'b0);
    endtask

    always @(negedge clk) begin
        compare_one("a", 0, a_s_ready, a_mem_we, a_mem_addr, a_mem_wdata,
                    a_core_rst, a_done, a_timeout, a_err_region, a_load_count);
        compare_one("b", 1, b_s_ready, {1'b0, b_mem_we}, b_mem_addr, b_mem_wdata,
                    b_core_rst, b_done, b_timeout, b_err_region, {12'd0, b_load_count});
        if (a_mem_we != 0) wr_cnt[0]++;
        if (b_mem_we != 0) wr_cnt[1]++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!a_s_ready && n < 40) begin @(negedge clk); n++; end
        check("wait_ready", a_s_ready, 1'b1);
    endtask

    // Holds the beat until A is ready, then returns at the negedge after
    // the accepting edge with s_valid still asserted.
    task automatic send_beat(input logic [1:0] r, input logic [31:0] a,
                             input logic [31:0] d, input logic last);
        s_valid = 1'b1; s_region = r; s_addr = a; s_data = d; s_last = last;
        wait_ready();
        @(negedge clk);
    endtask

    task automatic load_simple(input int n);
        for (int k = 0; k < n; k++)
            send_beat(2'd0, 32'(k), $urandom, k == n - 1);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (a_core_rst && n < 40) begin @(negedge clk); n++; end
        check("wait_run", a_core_rst, 1'b0);
    endtask

    task automatic halt_pulse();
        core_halt = 1'b1;
        @(negedge clk);
        core_halt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    logic [31:0] img [3];

    initial begin
        int n3, gap, a_wr0, b_wr0, cnt;
        logic [1:0] r;
        img[0] = 32'h0000_0013; img[1] = 32'h0050_0093; img[2] = 32'h0010_0073;

        // Reset for two cycles.
        repeat (2) @(negedge clk);
        check("rst_core_rst", a_core_rst, 1'b1);
        check("rst_s_ready", a_s_ready, 1'b0);
        check("rst_load_count", a_load_count, 16'd0);
        rst = 1'b0;

        // Basic three-beat load into IMEM.
        pulse_start();
        wait_ready();
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_region = 2'd0; s_addr = 32'(k); s_data = img[k]; s_last = (k == 2);
            @(negedge clk);
            check("l1_mem_we", a_mem_we, 4'b0001);
            check("l1_mem_addr", a_mem_addr, 32'(k));
            check("l1_mem_wdata", a_mem_wdata, img[k]);
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("l1_load_count", a_load_count, 16'd3);
        check("l1_drain_ready", a_s_ready, 1'b0);
        check("l1_drain_core_rst", a_core_rst, 1'b1);
        @(negedge clk);
        check("l1_run_core_rst", a_core_rst, 1'b0);
        check("l1_run_mem_we", a_mem_we, 4'b0000);

        // start in RUN is ignored; halt on the 20th RUN cycle.
        pulse_start();
        check("start_ignored_run", a_core_rst, 1'b0);
        repeat (18) @(negedge clk);
        halt_pulse();
        check("halt_done", a_done, 1'b1);
        check("halt_core_rst", a_core_rst, 1'b1);
        check("halt_timeout", a_timeout, 1'b0);
        check("b_short_wd_timeout", b_timeout, 1'b1);

        // Mixed regions with random backpressure; early valid during HOLD.
        a_wr0 = wr_cnt[0]; b_wr0 = wr_cnt[1]; n3 = 0;
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            r = (k < 3) ? 2'(k + 1) : 2'($urandom_range(0, 3));
            if (r == 2'd3) n3++;
            gap = (k > 0) ? $urandom_range(0, 2) : 0;
            if (gap > 0) begin
                s_valid = 1'b0; s_data = $urandom;
                repeat (gap) @(negedge clk);
            end
            send_beat(r, $urandom, $urandom, k == 11);
        end
        s_valid = 1'b0; s_last = 1'b0;
        wait_run();
        check("mix_a_writes", 32'(wr_cnt[0] - a_wr0), 32'd12);
        check("mix_b_writes", 32'(wr_cnt[1] - b_wr0), 32'(12 - n3));
        check("mix_a_count", a_load_count, 16'd12);
        check("mix_b_err_region", b_err_region, 1'b1);
        check("mix_a_err_region", a_err_region, 1'b0);
        repeat ($urandom_range(5, 40)) @(negedge clk);
        halt_pulse();
        check("mix_done", a_done, 1'b1);

        // Restart clears status; twenty beats saturate B's 4-bit count.
        pulse_start();
        check("restart_b_err_clear", b_err_region, 1'b0);
        check("restart_a_count_clear", a_load_count, 16'd0);
        for (int k = 0; k < 20; k++)
            send_beat(2'($urandom_range(0, 2)), $urandom, $urandom, k == 19);
        s_valid = 1'b0; s_last = 1'b0;
        check("sat_a_count", a_load_count, 16'd20);
        check("sat_b_count", b_load_count, 4'hf);
        wait_run();
        halt_pulse();

        // Watchdog: no halt, timeout after exactly 300 RUN cycles.
        pulse_start();
        load_simple(2);
        wait_run();
        cnt = 0;
        while (!a_core_rst && cnt < 400) begin cnt++; @(negedge clk); end
        check("tout_run_cycles", 32'(cnt), 32'd300);
        check("tout_timeout", a_timeout, 1'b1);
        check("tout_done", a_done, 1'b0);

        // Halt on RUN cycle 300 wins over expiry.
        pulse_start();
        load_simple(2);
        wait_run();
        repeat (299) @(negedge clk);
        halt_pulse();
        check("tie_done", a_done, 1'b1);
        check("tie_timeout", a_timeout, 1'b0);

        // Asynchronous reset mid-LOAD after two beats.
        pulse_start();
        send_beat(2'd1, 32'h10, 32'hdead_beef, 1'b0);
        send_beat(2'd2, 32'h11, 32'hcafe_f00d, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_s_ready", a_s_ready, 1'b0);
        check("arst_mem_we", a_mem_we, 4'b0000);
        check("arst_mem_addr", a_mem_addr, 32'd0);
        check("arst_mem_wdata", a_mem_wdata, 32'd0);
        check("arst_core_rst", a_core_rst, 1'b1);
        check("arst_done", a_done, 1'b0);
        check("arst_timeout", a_timeout, 1'b0);
        check("arst_err", a_err_region, 1'b0);
        check("arst_count", a_load_count, 16'd0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        load_simple(3);
        check("reload_count", a_load_count, 16'd3);
        wait_run();
        halt_pulse();
        check("reload_done", a_done, 1'b1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
